// File: rtl/branch_compare_serial.sv
// rtl/branch_compare_serial.sv - serial MSB-first branch compare unit, DIGIT bits per cycle
// Optional early exit on the first differing digit: BRCMP_EARLY_EXIT_EN
module branch_compare_serial #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iDataA,
    input  logic [WIDTH-1:0] iDataB,
    input  logic [2:0]       iFunct3,
    output logic             oValid,
    input  logic             iReady,
    output logic             oTaken,
    output logic             oLess,
    output logic             oEqual,
    output logic             oErr
);

    localparam int ND = WIDTH / DIGIT;
    localparam int CW = $clog2(ND + 1);
    localparam logic [CW-1:0] LAST = CW'(ND);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]      f3_q;
    logic            lt_q, gt_q;
    logic [CW-1:0]   cnt_q;
    logic            ready_q, valid_q, taken_q, less_q, equal_q, err_q;

    logic             sgn_d;
    logic [WIDTH-1:0] msb_mask_d;
    logic [DIGIT-1:0] dig_a_d, dig_b_d;
    logic             run_end_d;
    logic             taken_d, err_d;

    // Flipping the sign bit of both operands turns a signed compare into an unsigned one
    assign sgn_d      = iFunct3[2] & ~iFunct3[1];
    assign msb_mask_d = {sgn_d, {(WIDTH-1){1'b0}}};

    // Operands shift left each cycle so the digit under test is always at the top
    assign dig_a_d = a_q[WIDTH-1 -: DIGIT];
    assign dig_b_d = b_q[WIDTH-1 -: DIGIT];

`ifdef BRCMP_EARLY_EXIT_EN
    assign run_end_d = (cnt_q == LAST) || lt_q || gt_q;
`else
    assign run_end_d = (cnt_q == LAST);
`endif

    always_comb begin
        taken_d = 1'b0;
        err_d   = 1'b0;
        case (f3_q)
            3'b000:         taken_d = !lt_q && !gt_q;
            3'b001:         taken_d = lt_q || gt_q;
            3'b100, 3'b110: taken_d = lt_q;
            3'b101, 3'b111: taken_d = !lt_q;
            default:        err_d   = 1'b1;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            taken_q <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iValid) begin
                        a_q     <= iDataA ^ msb_mask_d;
                        b_q     <= iDataB ^ msb_mask_d;
                        f3_q    <= iFunct3;
                        lt_q    <= 1'b0;
                        gt_q    <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        taken_q <= 1'b0;
                        less_q  <= 1'b0;
                        equal_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_end_d) begin
                        valid_q <= 1'b1;
                        taken_q <= taken_d;
                        less_q  <= lt_q;
                        equal_q <= !lt_q && !gt_q;
                        err_q   <= err_d;
                        state_q <= S_DONE;
                    end else begin
                        if (!lt_q && !gt_q) begin
                            if (dig_a_d < dig_b_d) begin
                                lt_q <= 1'b1;
                            end else if (dig_a_d > dig_b_d) begin
                                gt_q <= 1'b1;
                            end
                        end
                        a_q   <= a_q << DIGIT;
                        b_q   <= b_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oTaken = taken_q;
    assign oLess  = less_q;
    assign oEqual = equal_q;
    assign oErr   = err_q;

endmodule
